// File: rtl/mem_block_mover_pkg.sv
// Shared types for the block-move engine: FSM state encoding and mode constants.
package mem_block_mover_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } mover_state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_block_mover.sv
// Block-move engine: forward byte-by-byte copy or constant fill of a memory region.
// All memory-side outputs decode from registered state, so there is no input-to-output path.
module mem_block_mover
    import mem_block_mover_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    mover_state_t      state_q, state_d;
    logic              mode_q,  mode_d;
    logic [ADDR_W-1:0] src_q,   src_d;
    logic [ADDR_W-1:0] dst_q,   dst_d;
    logic [ADDR_W-1:0] rem_q,   rem_d;
    logic [DATA_W-1:0] buf_q,   buf_d;
    logic [DATA_W-1:0] fill_q,  fill_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= MODE_COPY;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        buf_d     = buf_q;
        fill_d    = fill_q;
        busy      = 1'b0;
        done      = 1'b0;
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode;
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    rem_d  = length;
                    fill_d = fill_value;
                    if (length == '0)
                        state_d = DONE;
                    else if (mode == MODE_COPY)
                        state_d = RD;
                    else
                        state_d = WR;
                end
            end
            RD: begin
                busy     = 1'b1;
                mem_addr = src_q;
                mem_read = 1'b1;
                buf_d    = mem_rdata;
                src_d    = src_q + 1'b1;
                state_d  = WR;
            end
            WR: begin
                busy      = 1'b1;
                mem_addr  = dst_q;
                mem_write = 1'b1;
                mem_wdata = (mode_q == MODE_FILL) ? fill_q : buf_q;
                dst_d     = dst_q + 1'b1;
                rem_d     = rem_q - 1'b1;
                // Overlapping copies re-read freshly written bytes; that replication is intended.
                if (rem_q == ADDR_W'(1))
                    state_d = DONE;
                else if (mode_q == MODE_COPY)
                    state_d = RD;
                else
                    state_d = WR;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_block_mover.sv
// Scoreboard bench for mem_block_mover with an attached 256-byte memory and a reference memory image.
module tb_mem_block_mover;
    import mem_block_mover_pkg::*;

    logic       clk = 1'b0;
    logic       reset, start, mode;
    logic [7:0] src_addr, dst_addr, length, fill_value;
    logic       busy, done, mem_read, mem_write;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    logic       pl_we;
    logic [7:0] pl_addr, pl_data;
    logic [7:0] mem   [256];
    logic [7:0] model [256];

    typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
    typedef struct { int cyc; int nbusy; int nreads; } dn_t;
    wr_t wq[$];
    dn_t dq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int bcnt  = 0;
    int rcnt  = 0;

    mem_block_mover #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .fill_value(fill_value), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = mem_read ? mem[mem_addr] : 8'h00;
    always @(posedge clk) begin
        if (mem_write)  mem[mem_addr] <= mem_wdata;
        else if (pl_we) mem[pl_addr]  <= pl_data;
    end

    // Monitor: every write and every done pulse is checked against the scoreboard queues.
    always @(negedge clk) begin
        wr_t w;
        dn_t e;
        total++;
        if (mem_read && mem_write) begin
            bad++;
            $display("FAIL excl: mem_read=%0b mem_write=%0b both high at cyc %0d", mem_read, mem_write, cyc);
        end
        if (reset) begin
            bcnt = 0;
            rcnt = 0;
        end else begin
            if (busy)     bcnt++;
            if (mem_read) rcnt++;
        end
        if (mem_write) begin
            total++;
            if (wq.size() == 0) begin
                bad++;
                $display("FAIL write_unexp: addr=%0d data=%0d, none expected", mem_addr, mem_wdata);
            end else begin
                w = wq.pop_front();
                if (mem_addr !== w.a || mem_wdata !== w.d) begin
                    bad++;
                    $display("FAIL write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                             mem_addr, mem_wdata, w.a, w.d);
                end
            end
        end
        if (done) begin
            total++;
            if (dq.size() == 0) begin
                bad++;
                $display("FAIL done_unexp: done at cyc %0d, none expected", cyc);
            end else begin
                e = dq.pop_front();
                if (cyc != e.cyc) begin
                    bad++;
                    $display("FAIL done_cycle: got %0d expected %0d", cyc, e.cyc);
                end
                total++;
                if (bcnt != e.nbusy) begin
                    bad++;
                    $display("FAIL busy_cycles: got %0d expected %0d", bcnt, e.nbusy);
                end
                total++;
                if (rcnt != e.nreads) begin
                    bad++;
                    $display("FAIL read_cycles: got %0d expected %0d", rcnt, e.nreads);
                end
            end
            bcnt = 0;
            rcnt = 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 700 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("done_timeout", int'(seen), 1);
        @(posedge clk); #1;
        chk("wq_drained", wq.size(), 0);
    endtask

    // Reference: forward byte-by-byte over the model image; overlap falls out naturally.
    task automatic expect_op(input logic m, input logic [7:0] s, input logic [7:0] d,
                             input logic [7:0] l, input logic [7:0] f, input int nwr, input int n0);
        int li;
        li = int'(l);
        for (int i = 0; i < nwr; i++) begin
            logic [7:0] a, v;
            a = d + 8'(i);
            v = (m == MODE_FILL) ? f : model[s + 8'(i)];
            model[a] = v;
            wq.push_back('{a, v});
        end
        if (nwr == li)
            dq.push_back('{n0 + ((m == MODE_FILL) ? li : 2 * li),
                           (m == MODE_FILL) ? li : 2 * li,
                           (m == MODE_FILL) ? 0 : li});
    endtask

    task automatic run_op(input logic m, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l, input logic [7:0] f, input bit ign);
        mode = m; src_addr = s; dst_addr = d; length = l; fill_value = f;
        start = 1'b1;
        expect_op(m, s, d, l, f, int'(l), cyc + 1);
        @(posedge clk); #1;
        start = 1'b0;
        src_addr = 8'($urandom); dst_addr = 8'($urandom);
        length = 8'($urandom); fill_value = 8'($urandom); mode = ~m;
        if (ign) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            start = 1'b1;
            length = 8'd5;
            @(posedge clk); #1;
            start = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        for (int i = 0; i < 256; i++) model[i] = 8'($urandom);
        model[10] = 8'd11; model[11] = 8'd22; model[12] = 8'd33; model[13] = 8'd44;
        model[20] = 8'd7;
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) begin
            pl_we = 1'b1; pl_addr = 8'(i); pl_data = model[i];
            @(posedge clk); #1;
        end
        pl_we = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_mem_read", int'(mem_read), 0);
        chk("rst_mem_write", int'(mem_write), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(MODE_COPY, 8'd10, 8'd100, 8'd4, 8'h00, 1'b0);
        run_op(MODE_FILL, 8'd0, 8'd250, 8'd8, 8'hA5, 1'b0);
        run_op(MODE_COPY, 8'd5, 8'd50, 8'd0, 8'h00, 1'b0);
        run_op(MODE_COPY, 8'd20, 8'd21, 8'd3, 8'h00, 1'b1);
        chk("overlap_m23", int'(mem[23]), 7);

        // Reset lands at the end of cycle 6: three WR cycles commit, then the engine idles silently.
        mode = MODE_COPY; src_addr = 8'd30; dst_addr = 8'd130; length = 8'd10; start = 1'b1;
        expect_op(MODE_COPY, 8'd30, 8'd130, 8'd10, 8'h00, 3, cyc + 1);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_mem_read", int'(mem_read), 0);
        chk("midrst_mem_write", int'(mem_write), 0);
        chk("midrst_mem_addr", int'(mem_addr), 0);
        chk("midrst_mem_wdata", int'(mem_wdata), 0);
        repeat (4) begin @(posedge clk); #1; end
        chk("midrst_wq", wq.size(), 0);

        for (int n = 0; n < 25; n++) begin
            logic       m;
            logic [7:0] l;
            m = 1'($urandom_range(0, 1));
            l = ($urandom_range(0, 6) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
            run_op(m, 8'($urandom), 8'($urandom), l, 8'($urandom), 1'b0);
        end
        run_op(MODE_COPY, 8'd200, 8'd60, 8'd255, 8'h00, 1'b0);
        run_op(MODE_FILL, 8'd0, 8'd200, 8'd255, 8'h3C, 1'b0);

        repeat (2) @(posedge clk);
        chk("dq_drained", dq.size(), 0);
        for (int i = 0; i < 256; i++) begin
            total++;
            if (mem[i] !== model[i]) begin
                bad++;
                $display("FAIL mem_final[%0d]: got %0d expected %0d", i, mem[i], model[i]);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_block_mover.md
# mem_block_mover

Block-move engine sitting directly upstream of the 256-byte data memory. On a start pulse it copies `length` bytes from a source region to a destination region, or fills a destination region with a constant, by driving the memory's address, read-enable, write-enable and write-data inputs and consuming its combinational read data. It runs ahead of the core's memory stage. The external port mux grants it the memory whenever `busy` or `done` is high.

## Interface
- `ADDR_W`, default 8: address width; regions wrap modulo 2^ADDR_W.
- `DATA_W`, default 8: data width.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request pulse; sampled only in IDLE.
- `mode` in 1: 0 = copy, 1 = fill; latched at start.
- `src_addr` in ADDR_W: copy source base; latched at start; ignored in fill mode.
- `dst_addr` in ADDR_W: destination base; latched at start.
- `length` in ADDR_W: byte count; latched at start; 0 = no-op.
- `fill_value` in DATA_W: fill byte; latched at start.
- `busy` out 1: high while in RD or WR.
- `done` out 1: one-cycle completion pulse.
- `mem_addr` out ADDR_W: memory address.
- `mem_read` out 1: memory read enable.
- `mem_write` out 1: memory write enable.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data, combinational from `mem_addr` when `mem_read` is high.

## Operation
- States are IDLE, RD, WR and DONE.
- IDLE:
  - `start`=1 latches all inputs.
  - Then go to DONE if length==0; else RD if copy; else WR.
  - `start` in any other state is ignored.
- RD:
  - `mem_addr`=src_ptr, `mem_read`=1.
  - On the edge, capture `mem_rdata` into `buf`, increment src_ptr mod 2^ADDR_W, go to WR.
- WR:
  - `mem_addr`=dst_ptr, `mem_write`=1.
  - `mem_wdata`=`buf` in copy mode, latched `fill_value` in fill mode.
  - On the edge: increment dst_ptr, decrement remaining.
  - If remaining was 1, go to DONE; else go to RD (copy) or stay in WR (fill).
- DONE: `done`=1, no memory access, go to IDLE.
- Copy is strictly forward, byte by byte. With overlapping regions where dst > src, source bytes already overwritten are re-read, which replicates the pattern. That result is the defined behaviour.
- `mem_read` and `mem_write` are never high in the same cycle.
- Outside RD/WR: `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
- All outputs decode from registered state and pointers only (Moore). No input-to-output combinational path.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `done`, `mem_read`, `mem_write` = 0.
  - `mem_addr`, `mem_wdata`, pointers, remaining count, `buf` = 0.
- Reset mid-operation:
  - Return to IDLE on the next edge; no `done` pulse.
  - Bytes already written stay in memory. A WR cycle coinciding with the reset edge still commits its write.
- Start sampled at edge 0; first memory cycle is cycle 1.
- Copy of L bytes: cycles 1..2L alternate RD/WR, `done` in cycle 2L+1, IDLE at cycle 2L+2.
- Fill of L bytes: WR in cycles 1..L, `done` in cycle L+1.
- length==0: `done` in cycle 1; `busy` never rises.
- A new `start` is accepted in the first IDLE cycle after DONE, i.e. back-to-back with one cycle of gap.
- Address wrap: a pointer at 255 increments to 0. length 255 starting at 200 wraps cleanly.

## Structure
- Shared package `mem_block_mover_pkg`:
  - `mover_state_t` enum {IDLE, RD, WR, DONE}.
  - `MODE_COPY`=1'b0 and `MODE_FILL`=1'b1 constants.
- Single module, no sub-modules. One `always_ff` holds state, pointers, remaining count and buffers; one `always_comb` decodes outputs.

## Test plan
- Copy. Memory preloaded: M[10..13]=11,22,33,44. Start copy src=10, dst=100, len=4 → M[100..103]=11,22,33,44; `done` in cycle 9; `busy` high in cycles 1..8 exactly.
- Fill. Start fill dst=250, len=8, value=8'hA5 → M[250..255] and M[0..1]=A5; `done` in cycle 9; M[2] unchanged.
- Zero length. Start with len=0 → `done` in cycle 1; `mem_read`/`mem_write` never asserted.
- Overlap and ignored start. Start copy src=20, dst=21, len=3 with M[20]=7 → M[21..23]=7. A second `start` pulsed in cycle 3 is ignored; completion timing unchanged.
- Reset mid-copy. Copy len=10; assert `reset` during cycle 6 → next cycle IDLE with all outputs zero; no `done`; first 3 destination bytes written, rest untouched.
- Mutual exclusion. Every run in this plan: `mem_read` and `mem_write` are never both high.
